sdram_command_fsm: RTL and testbench

// Downstream stage of the AHB bus interface in the SDRAM controller. Consumes the

---
 rtl/sdram_command_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_sdram_command_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_command_fsm.sv
// SDRAM command sequencer behind the AHB interface: power-up init, periodic refresh,
// self-refresh, row open/close and single-beat column commands with read data capture.
module sdram_command_fsm #(
    parameter int unsigned T_INIT       = 100,
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned CAS_LAT      = 2,
    parameter int unsigned REF_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        select,
    input  logic        r_enable,
    input  logic        w_enable,
    input  logic        burst,
    input  logic        bus,
    input  logic        mode,
    input  logic [1:0]  bank,
    input  logic [12:0] row_addr,
    input  logic [9:0]  col_addr,
    input  logic [31:0] b_wdata,
    input  logic [31:0] dq_in,
    output logic        idle,
    output logic        chip,
    output logic        refresh_com,
    output logic [31:0] b_rdata,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic [3:0]  dqm,
    output logic [31:0] dq_out,
    output logic        dq_oe
);

    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdWr  = 4'b0100;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdRef = 4'b0001;
    localparam logic [3:0] CmdMrs = 4'b0000;

    localparam logic [12:0] PreAllAddr = 13'h0400;
    localparam logic [12:0] MrsAddr    = {6'b0, 3'(CAS_LAT), 4'b0000};

    typedef enum logic [3:0] {
        StInitWait, StInitRp, StInitRfc1, StInitRfc2, StIdle, StRefIssue,
        StRfcWait, StRcdWait, StRowOpen, StPreWait, StSelfRef, StSrExit
    } state_t;

    state_t               state_q;
    logic [3:0]           cmd_q;
    logic [15:0]          wait_q;
    logic [15:0]          ref_cnt_q;
    logic                 pend_q;
    logic [CAS_LAT-1:0]   rd_pipe_q;
    logic [1:0]           bank_q;
    logic [9:0]           col_q;
    logic                 wr_q;
    logic                 mode_q;

    logic                 counting;
    logic                 ref_wrap;
    logic                 pending_now;
    logic [9:0]           col_next;
    logic                 unused_burst;

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign unused_burst = burst;

    always_comb begin
        counting    = !(state_q inside {StInitWait, StInitRp, StInitRfc1, StInitRfc2, StSelfRef});
        ref_wrap    = counting && (ref_cnt_q == 16'(REF_INTERVAL - 1));
        pending_now = pend_q | ref_wrap;
        col_next    = mode_q ? col_q + 10'd1 : {col_q[9:2], col_q[1:0] + 2'd1};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StInitWait;
            cmd_q       <= 4'b1111;
            wait_q      <= '0;
            ref_cnt_q   <= '0;
            pend_q      <= 1'b0;
            rd_pipe_q   <= '0;
            bank_q      <= '0;
            col_q       <= '0;
            wr_q        <= 1'b0;
            mode_q      <= 1'b0;
            idle        <= 1'b0;
            chip        <= 1'b0;
            refresh_com <= 1'b0;
            b_rdata     <= '0;
            cke         <= 1'b0;
            ba          <= '0;
            addr        <= '0;
            dqm         <= 4'hF;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
        end else begin
            cmd_q       <= CmdNop;
            chip        <= 1'b0;
            refresh_com <= 1'b0;
            dq_oe       <= 1'b0;
            dqm         <= 4'hF;
            wait_q      <= wait_q + 16'd1;
            rd_pipe_q   <= {rd_pipe_q[CAS_LAT-2:0], 1'b0};
            if (rd_pipe_q[CAS_LAT-1]) begin
                b_rdata <= dq_in;
            end
            if (counting) begin
                ref_cnt_q <= ref_wrap ? 16'd0 : ref_cnt_q + 16'd1;
                if (ref_wrap) begin
                    pend_q <= 1'b1;
                end
            end

            unique case (state_q)
                StInitWait: begin
                    cke <= 1'b1;
                    if (wait_q == 16'(T_INIT)) begin
                        cmd_q   <= CmdPre;
                        addr    <= PreAllAddr;
                        wait_q  <= '0;
                        state_q <= StInitRp;
                    end
                end
                StInitRp: begin
                    if (wait_q == 16'(T_RP - 1)) begin
                        cmd_q   <= CmdRef;
                        wait_q  <= '0;
                        state_q <= StInitRfc1;
                    end
                end
                StInitRfc1: begin
                    if (wait_q == 16'(T_RFC - 1)) begin
                        cmd_q   <= CmdRef;
                        wait_q  <= '0;
                        state_q <= StInitRfc2;
                    end
                end
                StInitRfc2: begin
                    if (wait_q == 16'(T_RFC - 1)) begin
                        cmd_q   <= CmdMrs;
                        addr    <= MrsAddr;
                        idle    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    // A wrap landing on this very cycle still outranks a new request
                    if (pending_now) begin
                        refresh_com <= 1'b1;
                        idle        <= 1'b0;
                        state_q     <= StRefIssue;
                    end else if (!select) begin
                        cmd_q   <= CmdRef;
                        cke     <= 1'b0;
                        idle    <= 1'b0;
                        state_q <= StSelfRef;
                    end else if (r_enable ^ w_enable) begin
                        cmd_q   <= CmdAct;
                        ba      <= bank;
                        addr    <= row_addr;
                        bank_q  <= bank;
                        col_q   <= col_addr;
                        wr_q    <= w_enable;
                        mode_q  <= mode;
                        idle    <= 1'b0;
                        wait_q  <= '0;
                        state_q <= StRcdWait;
                    end
                end
                StRefIssue: begin
                    cmd_q   <= CmdRef;
                    pend_q  <= 1'b0;
                    wait_q  <= '0;
                    state_q <= StRfcWait;
                end
                StRfcWait, StSrExit, StPreWait: begin
                    // Leave one cycle early so IDLE can issue exactly at the timing boundary
                    if (wait_q == 16'((state_q == StPreWait) ? T_RP - 2 : T_RFC - 2)) begin
                        idle    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StRcdWait: begin
                    if (wait_q == 16'(T_RCD - 2)) begin
                        chip    <= 1'b1;
                        state_q <= StRowOpen;
                    end
                end
                StRowOpen: begin
                    if (bus) begin
                        cmd_q <= wr_q ? CmdWr : CmdRd;
                        ba    <= bank_q;
                        addr  <= {3'b000, col_q};
                        col_q <= col_next;
                        dqm   <= 4'h0;
                        if (wr_q) begin
                            dq_out <= b_wdata;
                            dq_oe  <= 1'b1;
                        end else begin
                            rd_pipe_q <= {rd_pipe_q[CAS_LAT-2:0], 1'b1};
                        end
                    end else if (!r_enable && !w_enable && rd_pipe_q == '0) begin
                        cmd_q   <= CmdPre;
                        addr    <= PreAllAddr;
                        wait_q  <= '0;
                        state_q <= StPreWait;
                    end
                end
                StSelfRef: begin
                    if (select) begin
                        cke       <= 1'b1;
                        ref_cnt_q <= '0;
                        wait_q    <= '0;
                        state_q   <= StSrExit;
                    end
                end
                default: state_q <= StInitWait;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_command_fsm.sv
// Directed bench for sdram_command_fsm: init sequence, column bursts from a vector table,
// and hand-written refresh, self-refresh and reset corner cases.
module tb_sdram_command_fsm;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        select = 1'b1;
    logic        r_enable = 1'b0;
    logic        w_enable = 1'b0;
    logic        burst = 1'b0;
    logic        bus = 1'b0;
    logic        mode = 1'b1;
    logic [1:0]  bank = '0;
    logic [12:0] row_addr = '0;
    logic [9:0]  col_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] dq_in = '0;
    logic        idle, chip, refresh_com, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
    logic [31:0] b_rdata, dq_out;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [3:0]  dqm;
    logic [3:0]  cmd;

    localparam logic [3:0] Nop = 4'b0111;
    localparam logic [3:0] Act = 4'b0011;
    localparam logic [3:0] Rd  = 4'b0101;
    localparam logic [3:0] Wr  = 4'b0100;
    localparam logic [3:0] Pre = 4'b0010;
    localparam logic [3:0] Ref = 4'b0001;
    localparam logic [3:0] Mrs = 4'b0000;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic           wr;
        logic           mode;
        logic [1:0]     bank;
        logic [12:0]    row;
        logic [9:0]     col;
        logic [31:0]    wdata;
        logic [3:0][9:0] cols;
    } vec_t;

    vec_t vecs[4];

    sdram_command_fsm dut (
        .clk(clk), .n_rst(n_rst), .select(select), .r_enable(r_enable),
        .w_enable(w_enable), .burst(burst), .bus(bus), .mode(mode), .bank(bank),
        .row_addr(row_addr), .col_addr(col_addr), .b_wdata(b_wdata), .dq_in(dq_in),
        .idle(idle), .chip(chip), .refresh_com(refresh_com), .b_rdata(b_rdata),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba),
        .addr(addr), .dqm(dqm), .dq_out(dq_out), .dq_oe(dq_oe)
    );

    assign cmd = {cs_n, ras_n, cas_n, we_n};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failed %0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // kind: 0 = command c on pins, 1 = idle, 2 = chip, 3 = refresh_com
    task automatic wait_ev(input string name, input int kind, input logic [3:0] c,
                           input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            case (kind)
                0: seen = (cmd == c);
                1: seen = (idle == 1'b1);
                2: seen = (chip == 1'b1);
                default: seen = (refresh_com == 1'b1);
            endcase
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_ctl"}, 64'({cke, cmd, ba, addr, dqm, idle, chip, refresh_com, dq_oe}),
            64'({1'b0, 4'hF, 2'b00, 13'h0, 4'hF, 4'b0000}));
        chk({name, "_data"}, {dq_out, b_rdata}, 64'h0);
    endtask

    // Expects n_rst low on entry; releases it and checks the full init sequence
    task automatic check_init(input string tag);
        bit bad_nop = 1'b0;
        bit bad_cke = 1'b0;
        tick();
        n_rst = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (cmd !== Nop) bad_nop = 1'b1;
            if (cke !== 1'b1) bad_cke = 1'b1;
        end
        chk({tag, "_nop_phase"}, 64'(bad_nop), 64'd0);
        chk({tag, "_cke_high"}, 64'(bad_cke), 64'd0);
        tick();
        chk({tag, "_pre_c101"}, 64'(cmd), 64'(Pre));
        chk({tag, "_pre_a10"}, 64'(addr[10]), 64'd1);
        repeat (2) tick();
        chk({tag, "_ref1_c103"}, 64'(cmd), 64'(Ref));
        repeat (7) tick();
        chk({tag, "_ref2_c110"}, 64'(cmd), 64'(Ref));
        repeat (7) tick();
        chk({tag, "_mrs_c117"}, 64'(cmd), 64'(Mrs));
        chk({tag, "_mrs_addr"}, 64'(addr), 64'h020);
        chk({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        bank = v.bank; row_addr = v.row; col_addr = v.col; mode = v.mode; burst = 1'b1;
        if (v.wr) w_enable = 1'b1; else r_enable = 1'b1;
        wait_ev({p, "_act_seen"}, 0, Act, 40);
        chk({p, "_act_ba"}, 64'(ba), 64'(v.bank));
        chk({p, "_act_row"}, 64'(addr), 64'(v.row));
        bank = ~v.bank; col_addr = ~v.col; mode = ~v.mode;
        wait_ev({p, "_chip_seen"}, 2, Nop, 10);
        for (int b = 0; b < 4; b++) begin
            bus = 1'b1;
            b_wdata = v.wdata + 32'(b);
            tick();
            chk($sformatf("%s_cmd%0d", p, b), 64'(cmd), 64'(v.wr ? Wr : Rd));
            chk($sformatf("%s_col%0d", p, b), 64'(addr), 64'({3'b000, v.cols[b]}));
            chk($sformatf("%s_ba%0d", p, b), 64'(ba), 64'(v.bank));
            chk($sformatf("%s_dqm%0d", p, b), 64'(dqm), 64'h0);
            chk($sformatf("%s_oe%0d", p, b), 64'(dq_oe), 64'(v.wr));
            if (v.wr) chk($sformatf("%s_wd%0d", p, b), 64'(dq_out), 64'(v.wdata + 32'(b)));
        end
        bus = 1'b0; r_enable = 1'b0; w_enable = 1'b0; burst = 1'b0;
        wait_ev({p, "_pre_seen"}, 0, Pre, 8);
        wait_ev({p, "_idle_back"}, 1, Nop, 6);
    endtask

    // Second refresh_com comes from a wrap in IDLE, so the counter is 0 right after it
    task automatic sync_refresh(input string tag);
        wait_ev({tag, "_sync_a"}, 3, Nop, 1700);
        wait_ev({tag, "_sync_b"}, 3, Nop, 1700);
    endtask

    initial begin
        bit bad;
        bit acted;

        vecs[0] = '{wr: 1'b0, mode: 1'b0, bank: 2'd2, row: 13'h01AB, col: 10'd6,
                    wdata: 32'h0, cols: {10'd5, 10'd4, 10'd7, 10'd6}};
        vecs[1] = '{wr: 1'b0, mode: 1'b1, bank: 2'd3, row: 13'h1FFF, col: 10'd1022,
                    wdata: 32'h0, cols: {10'd1, 10'd0, 10'd1023, 10'd1022}};
        vecs[2] = '{wr: 1'b1, mode: 1'b1, bank: 2'd0, row: 13'h0007, col: 10'd16,
                    wdata: 32'hCAFE0000, cols: {10'd19, 10'd18, 10'd17, 10'd16}};
        vecs[3] = '{wr: 1'b1, mode: 1'b0, bank: 2'd1, row: 13'h0ABC, col: 10'd1023,
                    wdata: 32'h0BAD0000, cols: {10'd1022, 10'd1021, 10'd1020, 10'd1023}};

        repeat (2) tick();
        chk_reset_outs("reset");
        check_init("init");

        // Single write; bus raised during RCD must not produce a column command
        bank = 2'd1; row_addr = 13'd5; col_addr = 10'd8; mode = 1'b1; w_enable = 1'b1;
        wait_ev("wr_act_seen", 0, Act, 20);
        chk("wr_act_ba", 64'(ba), 64'd1);
        chk("wr_act_row", 64'(addr), 64'd5);
        bus = 1'b1; b_wdata = 32'hDEADBEEF;
        tick();
        chk("early_bus_ignored", 64'(cmd), 64'(Nop));
        chk("wr_chip_pulse", 64'(chip), 64'd1);
        tick();
        chk("wr_cmd", 64'(cmd), 64'(Wr));
        chk("wr_addr", 64'(addr), 64'd8);
        chk("wr_data", 64'({dq_out, dq_oe, dqm}), 64'({32'hDEADBEEF, 1'b1, 4'h0}));
        bus = 1'b0; w_enable = 1'b0;
        tick();
        chk("wr_pre", 64'({cmd, addr[10]}), 64'({Pre, 1'b1}));
        wait_ev("wr_idle_back", 1, Nop, 4);

        // Single read: capture lands CAS_LAT cycles after RD, PRE waits for it
        dq_in = 32'h12345678;
        bank = 2'd0; row_addr = 13'd1; col_addr = 10'd2; r_enable = 1'b1;
        wait_ev("rd_act_seen", 0, Act, 20);
        wait_ev("rd_chip_seen", 2, Nop, 6);
        bus = 1'b1;
        tick();
        chk("rd_cmd", 64'({cmd, addr}), 64'({Rd, 13'd2}));
        bus = 1'b0; r_enable = 1'b0;
        tick();
        chk("rd_not_early", 64'(b_rdata), 64'h0);
        chk("rd_hold_pre1", 64'(cmd), 64'(Nop));
        tick();
        chk("rd_capture", 64'(b_rdata), 64'h12345678);
        chk("rd_hold_pre2", 64'(cmd), 64'(Nop));
        tick();
        chk("rd_pre", 64'(cmd), 64'(Pre));
        wait_ev("rd_idle_back", 1, Nop, 4);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i);
        end

        // Counter wraps while the row is open: refresh waits for PRE and IDLE
        sync_refresh("rowref");
        repeat (770) tick();
        bank = 2'd2; row_addr = 13'd9; col_addr = 10'd0; r_enable = 1'b1;
        bad = 1'b0; acted = 1'b0;
        for (int k = 771; k <= 795; k++) begin
            tick();
            if (cmd == Ref || refresh_com) bad = 1'b1;
            if (cmd == Act) acted = 1'b1;
        end
        chk("rowref_act", 64'(acted), 64'd1);
        chk("rowref_no_ref_open", 64'(bad), 64'd0);
        r_enable = 1'b0;
        wait_ev("rowref_pre", 0, Pre, 4);
        wait_ev("rowref_refcom", 3, Nop, 6);
        tick();
        chk("rowref_ref", 64'(cmd), 64'(Ref));
        wait_ev("rowref_idle", 1, Nop, 10);

        // Wrap coincides with a new write request in IDLE
        sync_refresh("coinc");
        repeat (779) tick();
        bank = 2'd3; row_addr = 13'h0123; col_addr = 10'd5; w_enable = 1'b1;
        tick();
        chk("coinc_refcom", 64'({refresh_com, idle}), 64'({1'b1, 1'b0}));
        chk("coinc_no_act", 64'(cmd), 64'(Nop));
        tick();
        chk("coinc_ref", 64'(cmd), 64'(Ref));
        wait_ev("coinc_act_seen", 0, Act, 15);
        chk("coinc_act", 64'({ba, addr}), 64'({2'd3, 13'h0123}));
        w_enable = 1'b0;
        wait_ev("coinc_pre", 0, Pre, 6);
        wait_ev("coinc_idle", 1, Nop, 4);

        // Self-refresh entry and exit
        select = 1'b0;
        tick();
        chk("sr_entry", 64'({cmd, cke, idle}), 64'({Ref, 1'b0, 1'b0}));
        repeat (3) tick();
        chk("sr_hold", 64'({cmd, cke, idle}), 64'({Nop, 1'b0, 1'b0}));
        select = 1'b1;
        tick();
        chk("sr_exit_cke", 64'({cmd, cke, idle}), 64'({Nop, 1'b1, 1'b0}));
        repeat (5) tick();
        chk("sr_exit_wait", 64'(idle), 64'd0);
        tick();
        chk("sr_exit_idle", 64'(idle), 64'd1);

        // Reset in the middle of a write burst
        bank = 2'd1; row_addr = 13'd2; col_addr = 10'd3; mode = 1'b1; w_enable = 1'b1;
        wait_ev("mid_act_seen", 0, Act, 20);
        wait_ev("mid_chip_seen", 2, Nop, 6);
        bus = 1'b1; b_wdata = 32'hA5A5A5A5;
        tick();
        chk("mid_wr", 64'({cmd, dq_oe}), 64'({Wr, 1'b1}));
        #2 n_rst = 1'b0;
        #1 chk_reset_outs("mid_reset");
        bus = 1'b0; w_enable = 1'b0;
        check_init("reinit");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
